// File: rtl/mem_pkg.sv
// Shared definitions for the AXI4-Lite load/store initiator.
//   - access size encodings carried on req_size
//   - AXI response codes
//   - master FSM state enum
//   - alignment helper, only used when MEM_ALIGN_CHECK_EN is defined
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp,
        StResp
    } state_e;

    // The reserved size encoding 3 is treated as a word access.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
        if (size == SIZE_B) begin
            return 1'b0;
        end
        if (size == SIZE_H) begin
            return addr_lo[0];
        end
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between the initiator (master modport) and the memory
// responder (slave modport).
//   AW: awvalid, awready, awaddr      W: wvalid, wready, wdata[32], wstrb[4]
//   B : bvalid, bready, bresp[2]      AR: arvalid, arready, araddr
//   R : rvalid, rready, rdata[32], rresp[2]
interface axi_lite_master_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane steering for 32-bit load/store data.
//   size_i, addr_lo_i : access size and byte offset within the word
//   unsigned_i        : zero-extend (1) or sign-extend (0) sub-word loads
//   wdata_i           : right-aligned store data
//   rdata_i           : raw bus read word
//   wstrb_o, wdata_o  : byte strobes and lane-replicated store data
//   rdata_o           : extracted and extended load data
module lsu_data_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [15:0] shifted;
    logic        sign_b;
    logic        sign_h;

    always_comb begin
        shifted = 16'(rdata_i >> {addr_lo_i, 3'b000});
        sign_b  = ~unsigned_i & shifted[7];
        sign_h  = ~unsigned_i & shifted[15];
        case (size_i)
            SIZE_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_b}}, shifted[7:0]};
            end
            SIZE_H: begin
                // A half at offset 3 keeps only the lane that fits in the word.
                wstrb_o = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_h}}, shifted[15:0]};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one outstanding byte/half/word load or store turned into
// an AR/R or AW+W/B transaction on io_mem, response returned on resp_*.
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   req_*              : request handshake (valid/ready) with write/addr/size/unsigned/wdata
//   resp_*             : response handshake with extended rdata and bus error code
//   io_mem             : AXI4-Lite master port
//   misaligned         : only with MEM_ALIGN_CHECK_EN; pulses with a rejected response
// Build option MEM_ALIGN_CHECK_EN: reject misaligned half/word accesses locally.
module axi_lite_master
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_err,
    axi_lite_master_if.master     io_mem
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  misaligned
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            err_q, err_d;
    logic                  accept;
    logic                  reject;
    logic                  aw_hs;
    logic                  w_hs;

    assign accept = (state_q == StIdle) && req_valid;
    assign aw_hs  = (state_q == StWrReq) && !aw_done_q && io_mem.awready;
    assign w_hs   = (state_q == StWrReq) && !w_done_q && io_mem.wready;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign reject     = is_misaligned(req_size, req_addr[1:0]);
    assign misaligned = (state_q == StResp) && misalign_q;
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (reject) begin
                        state_d = StResp;
                    end else begin
                        state_d = req_write ? StWrReq : StRdAddr;
                    end
                end
            end
            StRdAddr: if (io_mem.arready) state_d = StRdData;
            StRdData: if (io_mem.rvalid) state_d = StResp;
            StWrReq: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: if (io_mem.bvalid) state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Valids depend only on registered state, never on the same-cycle ready.
    always_comb begin
        req_ready      = (state_q == StIdle);
        resp_valid     = (state_q == StResp);
        io_mem.arvalid = (state_q == StRdAddr);
        io_mem.rready  = (state_q == StRdData);
        io_mem.awvalid = (state_q == StWrReq) && !aw_done_q;
        io_mem.wvalid  = (state_q == StWrReq) && !w_done_q;
        io_mem.bready  = (state_q == StWrResp);
    end

    assign io_mem.araddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign io_mem.awaddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign resp_err      = err_q;

    always_comb begin
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        if (accept) begin
            addr_d    = req_addr;
            size_d    = req_size;
            uns_d     = req_unsigned;
            wdata_d   = req_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            // Stores and rejected accesses report zero data.
            rdata_d   = '0;
            err_d     = reject ? RESP_SLVERR : RESP_OKAY;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_d = reject;
`endif
        end
        if ((state_q == StRdData) && io_mem.rvalid) begin
            rdata_d = io_mem.rdata;
            err_d   = io_mem.rresp;
        end
        if ((state_q == StWrResp) && io_mem.bvalid) begin
            err_d = io_mem.bresp;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            size_q    <= SIZE_W;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= RESP_OKAY;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    lsu_data_align u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (rdata_q),
        .wstrb_o    (io_mem.wstrb),
        .wdata_o    (io_mem.wdata),
        .rdata_o    (resp_rdata)
    );

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master with a negedge-driven AXI-Lite responder.
// Build option MEM_ALIGN_CHECK_EN selects the misaligned-rejection scenario.
module tb_axi_lite_master;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    axi_lite_master_if #(.ADDR_WIDTH(32)) io_mem ();

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .io_mem       (io_mem)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    always #5 clock = ~clock;

    // Responder configuration (written by tests) and observations (written by responder).
    int          ar_wait = 0, aw_wait = 0, w_wait = 0;
    bit          r_hold = 1'b0;
    logic [31:0] r_data_cfg = '0;
    logic [1:0]  r_resp_cfg = '0, b_resp_cfg = '0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0, stab_err = 0, cyc = 0;
    int          aw_cyc = 0, w_cyc = 0;
    logic [31:0] ar_addr = '0, aw_addr = '0, w_data = '0, ar_last = '0, aw_last = '0;
    logic [31:0] w_last = '0;
    logic [3:0]  w_strb = '0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    bit          r_pend, r_done, b_pend, b_done, aw_got, w_got, ar_stall, aw_stall, w_stall;

    // Readies decided at negedge; a handshake seen here completes at the next posedge.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            io_mem.arready = 0; io_mem.awready = 0; io_mem.wready = 0;
            io_mem.rvalid = 0; io_mem.bvalid = 0; io_mem.rdata = '0;
            io_mem.rresp = '0; io_mem.bresp = '0;
            r_pend = 0; r_done = 0; b_pend = 0; b_done = 0; aw_got = 0; w_got = 0;
            ar_stall = 0; aw_stall = 0; w_stall = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            if (r_done) begin io_mem.rvalid = 0; r_done = 0; end
            if (r_pend && !r_hold) begin
                io_mem.rvalid = 1; io_mem.rdata = r_data_cfg; io_mem.rresp = r_resp_cfg;
                r_pend = 0;
            end
            if (io_mem.rvalid && io_mem.rready) begin r_hs++; r_done = 1; end
            if (b_done) begin io_mem.bvalid = 0; b_done = 0; end
            if (b_pend) begin io_mem.bvalid = 1; io_mem.bresp = b_resp_cfg; b_pend = 0; end
            if (io_mem.bvalid && io_mem.bready) begin b_hs++; b_done = 1; end

            if (ar_stall && (io_mem.arvalid !== 1'b1 || io_mem.araddr !== ar_last)) stab_err++;
            io_mem.arready = io_mem.arvalid && (ar_cnt >= ar_wait);
            ar_stall = 0;
            if (io_mem.arvalid) begin
                if (io_mem.arready) begin
                    ar_hs++; ar_addr = io_mem.araddr; r_pend = 1; ar_cnt = 0;
                end else begin
                    ar_cnt++; ar_stall = 1; ar_last = io_mem.araddr;
                end
            end

            if (aw_stall && (io_mem.awvalid !== 1'b1 || io_mem.awaddr !== aw_last)) stab_err++;
            io_mem.awready = io_mem.awvalid && (aw_cnt >= aw_wait);
            aw_stall = 0;
            if (io_mem.awvalid) begin
                if (io_mem.awready) begin
                    aw_hs++; aw_addr = io_mem.awaddr; aw_got = 1; aw_cnt = 0; aw_cyc = cyc;
                end else begin
                    aw_cnt++; aw_stall = 1; aw_last = io_mem.awaddr;
                end
            end

            if (w_stall && (io_mem.wvalid !== 1'b1 || io_mem.wdata !== w_last)) stab_err++;
            io_mem.wready = io_mem.wvalid && (w_cnt >= w_wait);
            w_stall = 0;
            if (io_mem.wvalid) begin
                if (io_mem.wready) begin
                    w_hs++; w_data = io_mem.wdata; w_strb = io_mem.wstrb; w_got = 1;
                    w_cnt = 0; w_cyc = cyc;
                end else begin
                    w_cnt++; w_stall = 1; w_last = io_mem.wdata;
                end
            end
            if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] d);
        int k;
        @(negedge clock);
        req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = d;
        req_valid = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin @(negedge clock); k++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL req_accept: req_ready=%b required 1", req_ready);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge.
    task automatic collect(input string tag, input int lat, input int hold);
        int   n;
        exp_t e;
        bit   stable;
        n = 1;
        while (resp_valid !== 1'b1 && n < 64) begin @(negedge clock); n++; end
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s resp_timeout: resp_valid=%b required 1", tag, resp_valid);
        end
        n_checks++;
        if (n != lat) begin
            n_fail++; $display("FAIL %s latency: got %0d required %0d", tag, n, lat);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL %s scoreboard_empty: size 0 required >0", tag);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        n_checks++;
        if (resp_rdata !== e.rdata) begin
            n_fail++; $display("FAIL %s rdata: got %h required %h", tag, resp_rdata, e.rdata);
        end
        n_checks++;
        if (resp_err !== e.err) begin
            n_fail++; $display("FAIL %s err: got %b required %b", tag, resp_err, e.err);
        end
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== e.rdata ||
                resp_err !== e.err) stable = 1'b0;
            @(negedge clock);
        end
        if (hold > 0) begin
            n_checks++;
            if (stable !== 1'b1 || resp_err !== e.err || resp_valid !== 1'b1) begin
                n_fail++; $display("FAIL %s hold: stable=%b err=%b required 1/%b", tag,
                                   stable, resp_err, e.err);
            end
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        n_checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL %s release: valid/ready=%b%b required 01", tag,
                               resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({io_mem.arvalid, io_mem.awvalid, io_mem.wvalid, io_mem.bready, io_mem.rready,
             resp_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_valids: some valid/ready high, required all 0");
        end
        n_checks++;
        if ({resp_rdata, resp_err} !== 34'b0) begin
            n_fail++; $display("FAIL reset_resp: rdata=%h err=%b required 0", resp_rdata, resp_err);
        end
        #21 reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_word_load();
        int ar0;
        ar0 = ar_hs; ar_wait = 0; r_data_cfg = 32'hDEADBEEF; r_resp_cfg = RESP_OKAY;
        exp_q.push_back('{rdata: 32'hDEADBEEF, err: RESP_OKAY});
        issue(1'b0, 32'h8000_0004, SIZE_W, 1'b0, '0);
        collect("word_load", 3, 0);
        n_checks++;
        if (ar_hs - ar0 != 1 || ar_addr !== 32'h8000_0004) begin
            n_fail++; $display("FAIL word_load araddr: %0d x %h required 1 x 80000004",
                               ar_hs - ar0, ar_addr);
        end
    endtask

    task automatic test_sub_word_load();
        logic [31:0] addr_t[5] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                                   32'h8000_0000, 32'h8000_0001};
        logic [1:0]  size_t[5] = '{SIZE_B, SIZE_B, SIZE_H, SIZE_H, SIZE_B};
        logic        uns_t[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] data_t[5] = '{32'h8500_0000, 32'h8500_0000, 32'h8001_1234,
                                   32'h0000_F00F, 32'h0000_7F00};
        logic [31:0] exp_t_[5] = '{32'hFFFF_FF85, 32'h0000_0085, 32'hFFFF_8001,
                                   32'h0000_F00F, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            r_data_cfg = data_t[i]; r_resp_cfg = RESP_OKAY;
            exp_q.push_back('{rdata: exp_t_[i], err: RESP_OKAY});
            issue(1'b0, addr_t[i], size_t[i], uns_t[i], '0);
            collect($sformatf("sub_load%0d", i), 3, 0);
        end
    endtask

    task automatic test_read_err_wait();
        ar_wait = 2; r_data_cfg = 32'h0BAD_F00D; r_resp_cfg = RESP_SLVERR;
        exp_q.push_back('{rdata: 32'h0BAD_F00D, err: RESP_SLVERR});
        issue(1'b0, 32'h8000_0010, SIZE_W, 1'b0, '0);
        collect("read_err", 5, 0);
        ar_wait = 0;
    endtask

    task automatic test_half_store();
        int aw0, w0, b0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        aw_wait = 3; w_wait = 0; b_resp_cfg = RESP_OKAY;
        exp_q.push_back('{rdata: 32'h0, err: RESP_OKAY});
        issue(1'b1, 32'h8000_0002, SIZE_H, 1'b0, 32'h0000_1234);
        collect("half_store", 6, 0);
        n_checks++;
        if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
            n_fail++; $display("FAIL half_store hs_counts: aw=%0d w=%0d b=%0d required 1/1/1",
                               aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
        n_checks++;
        if (aw_cyc - w_cyc != 3) begin
            n_fail++; $display("FAIL half_store w_lead: got %0d required 3", aw_cyc - w_cyc);
        end
        n_checks++;
        if ({aw_addr, w_data, w_strb} !== {32'h8000_0000, 32'h1234_1234, 4'b1100}) begin
            n_fail++; $display("FAIL half_store lanes: addr=%h data=%h strb=%b required %s",
                               aw_addr, w_data, w_strb, "80000000/12341234/1100");
        end
        aw_wait = 0;
    endtask

    task automatic test_store_err_backpressure();
        b_resp_cfg = RESP_DECERR;
        exp_q.push_back('{rdata: 32'h0, err: RESP_DECERR});
        issue(1'b1, 32'h8000_0001, SIZE_B, 1'b0, 32'h0000_00A5);
        collect("store_err", 3, 5);
        n_checks++;
        if ({w_data, w_strb} !== {32'hA5A5_A5A5, 4'b0010}) begin
            n_fail++; $display("FAIL store_err lanes: data=%h strb=%b required A5A5A5A5/0010",
                               w_data, w_strb);
        end
        b_resp_cfg = RESP_OKAY;
    endtask

    task automatic test_reset_mid();
        r_hold = 1'b1; r_data_cfg = 32'h1111_1111;
        issue(1'b0, 32'h8000_0020, SIZE_W, 1'b0, '0);
        @(negedge clock);
        n_checks++;
        if (io_mem.rready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid in_rd_data: rready=%b required 1", io_mem.rready);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({io_mem.arvalid, io_mem.rready, resp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid async: ar/r/resp=%b%b%b required 000",
                               io_mem.arvalid, io_mem.rready, resp_valid);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        r_hold = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_mid release: ready/valid=%b%b required 10",
                               req_ready, resp_valid);
        end
    endtask

    task automatic test_misaligned();
        int ar0, aw0;
        ar0 = ar_hs; aw0 = aw_hs;
`ifdef MEM_ALIGN_CHECK_EN
        exp_q.push_back('{rdata: 32'h0, err: RESP_SLVERR});
        issue(1'b0, 32'h8000_0001, SIZE_W, 1'b0, '0);
        n_checks++;
        if ({resp_valid, misaligned} !== 2'b11) begin
            n_fail++; $display("FAIL misaligned pulse: valid/mis=%b%b required 11",
                               resp_valid, misaligned);
        end
        collect("misaligned_load", 1, 0);
        exp_q.push_back('{rdata: 32'h0, err: RESP_SLVERR});
        issue(1'b1, 32'h8000_0003, SIZE_H, 1'b0, 32'h0000_BEEF);
        collect("misaligned_store", 1, 0);
        n_checks++;
        if (ar_hs - ar0 != 0 || aw_hs - aw0 != 0) begin
            n_fail++; $display("FAIL misaligned no_bus: ar=%0d aw=%0d required 0/0",
                               ar_hs - ar0, aw_hs - aw0);
        end
`else
        r_data_cfg = 32'h1122_3344; r_resp_cfg = RESP_OKAY;
        exp_q.push_back('{rdata: 32'h1122_3344, err: RESP_OKAY});
        issue(1'b0, 32'h8000_0001, SIZE_W, 1'b0, '0);
        collect("unaligned_load", 3, 0);
        exp_q.push_back('{rdata: 32'h0, err: RESP_OKAY});
        issue(1'b1, 32'h8000_0003, SIZE_H, 1'b0, 32'h0000_BEEF);
        collect("unaligned_store", 3, 0);
        n_checks++;
        if (ar_hs - ar0 != 1 || aw_hs - aw0 != 1 || ar_addr !== 32'h8000_0000 ||
            {w_data, w_strb} !== {32'hBEEF_BEEF, 4'b1000}) begin
            n_fail++; $display("FAIL unaligned bus: ar=%0d aw=%0d addr=%h data=%h strb=%b",
                               ar_hs - ar0, aw_hs - aw0, ar_addr, w_data, w_strb);
        end
`endif
    endtask

    task automatic test_back_to_back();
        r_data_cfg = 32'hCAFE_0001; r_resp_cfg = RESP_OKAY;
        exp_q.push_back('{rdata: 32'h0, err: RESP_OKAY});
        issue(1'b1, 32'h8000_0040, SIZE_W, 1'b0, 32'h5566_7788);
        collect("b2b_store", 3, 0);
        exp_q.push_back('{rdata: 32'hCAFE_0001, err: RESP_OKAY});
        issue(1'b0, 32'h8000_0040, SIZE_W, 1'b0, '0);
        collect("b2b_load", 3, 0);
        n_checks++;
        if (stab_err != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL protocol: stability errors %0d queue %0d required 0/0",
                               stab_err, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_sub_word_load();
        test_read_err_wait();
        test_half_store();
        test_store_err_backpressure();
        test_reset_mid();
        test_misaligned();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
